// File: rtl/cpu_types_pkg.sv
// Shared ISA encodings, decoded control bundle and decode-stage state for the CPU pipeline.
// Field widths of decode_ctrl_t are fixed by REG_W; decode_stage's REG_AW is expected to match.
package cpu_types_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9
  } aluop_t;

  // Writeback source select; MTR_IMM lets LUI write its shifted immediate directly.
  typedef enum logic [1:0] {
    MTR_ALU  = 2'd0,
    MTR_MEM  = 2'd1,
    MTR_LINK = 2'd2,
    MTR_IMM  = 2'd3
  } memtoreg_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } stage_state_t;

  typedef struct packed {
    aluop_t    aluop;
    regbits_t  rsel1;
    regbits_t  rsel2;
    regbits_t  wsel;
    logic      WEN;
    logic      dREN;
    logic      dWEN;
    logic      irsel;
    memtoreg_t memtoreg;
    logic      branch_eq;
    logic      branch_ne;
    logic      jump;
    logic      jump_reg;
    logic      link;
    logic      halt;
    logic      illegal;
  } decode_ctrl_t;

  function automatic aluop_t funct_alu(input logic [5:0] fn);
    case (fn)
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      FN_SLTU: return ALU_SLTU;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic aluop_t itype_alu(input logic [5:0] op);
    case (op)
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake, EX load-hazard hints and the decode-to-EX output bundle.
interface decode_stage_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) ();

  logic [WORD_W-1:0] instr_i;
  logic              in_valid;
  logic              in_ready;
  logic              flush_i;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_wsel_i;
  logic              out_valid;
  logic              out_ready;
  decode_ctrl_t      ctrl_o;
  logic [WORD_W-1:0] imm_o;

  modport master (
    output instr_i, in_valid, flush_i, ex_memread_i, ex_wsel_i, out_ready,
    input  in_ready, out_valid, ctrl_o, imm_o
  );

  modport slave (
    input  instr_i, in_valid, flush_i, ex_memread_i, ex_wsel_i, out_ready,
    output in_ready, out_valid, ctrl_o, imm_o
  );

endinterface

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode into the control bundle and extended immediate.
// Register selects for unused operands are forced to 0 so they never raise a false load-use hazard.
module instr_decoder
  import cpu_types_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int LUI_SHIFT = 16
) (
  input  logic [WORD_W-1:0] instr,
  output decode_ctrl_t      ctrl,
  output logic [WORD_W-1:0] imm,
  output logic              rt_used
);

  logic [5:0]        op;
  logic [5:0]        fn;
  regbits_t          rs;
  regbits_t          rt;
  regbits_t          rd;
  logic [WORD_W-1:0] imm_sx;
  logic [WORD_W-1:0] imm_zx;
  logic [WORD_W-1:0] shamt_zx;
  logic [WORD_W-1:0] addr_zx;
  logic              legal;

  assign op       = instr[31:26];
  assign fn       = instr[5:0];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm_sx   = {{(WORD_W-16){instr[15]}}, instr[15:0]};
  assign imm_zx   = {{(WORD_W-16){1'b0}}, instr[15:0]};
  assign shamt_zx = {{(WORD_W-5){1'b0}}, instr[10:6]};
  assign addr_zx  = {{(WORD_W-26){1'b0}}, instr[25:0]};

  always_comb begin
    ctrl          = '0;
    ctrl.aluop    = ALU_ADD;
    ctrl.memtoreg = MTR_ALU;
    imm           = '0;
    rt_used       = 1'b0;
    legal         = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL: begin
            ctrl.rsel2 = rt;
            rt_used    = 1'b1;
            ctrl.wsel  = rd;
            ctrl.WEN   = 1'b1;
            ctrl.irsel = 1'b1;
            ctrl.aluop = (fn == FN_SLL) ? ALU_SLL : ALU_SRL;
            imm        = shamt_zx;
          end
          FN_JR: begin
            ctrl.rsel1    = rs;
            ctrl.jump_reg = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            ctrl.rsel1 = rs;
            ctrl.rsel2 = rt;
            rt_used    = 1'b1;
            ctrl.wsel  = rd;
            ctrl.WEN   = 1'b1;
            ctrl.aluop = funct_alu(fn);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.rsel1 = rs;
        ctrl.wsel  = rt;
        ctrl.WEN   = 1'b1;
        ctrl.irsel = 1'b1;
        ctrl.aluop = itype_alu(op);
        imm        = (op == OP_ADDI || op == OP_ADDIU || op == OP_SLTI) ? imm_sx : imm_zx;
      end
      OP_LUI: begin
        ctrl.wsel     = rt;
        ctrl.WEN      = 1'b1;
        ctrl.irsel    = 1'b1;
        ctrl.memtoreg = MTR_IMM;
        imm           = imm_zx << LUI_SHIFT;
      end
      OP_LW: begin
        ctrl.rsel1    = rs;
        ctrl.wsel     = rt;
        ctrl.WEN      = 1'b1;
        ctrl.dREN     = 1'b1;
        ctrl.irsel    = 1'b1;
        ctrl.memtoreg = MTR_MEM;
        imm           = imm_sx;
      end
      OP_SW: begin
        ctrl.rsel1 = rs;
        ctrl.rsel2 = rt;
        rt_used    = 1'b1;
        ctrl.dWEN  = 1'b1;
        ctrl.irsel = 1'b1;
        imm        = imm_sx;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.rsel1     = rs;
        ctrl.rsel2     = rt;
        rt_used        = 1'b1;
        ctrl.aluop     = ALU_SUB;
        ctrl.branch_eq = (op == OP_BEQ);
        ctrl.branch_ne = (op == OP_BNE);
        imm            = imm_sx;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
        imm       = addr_zx;
      end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.wsel     = regbits_t'(31);
        ctrl.WEN      = 1'b1;
        ctrl.memtoreg = MTR_LINK;
        imm           = addr_zx;
      end
      OP_HALT: ctrl.halt = 1'b1;
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      imm          = '0;
      rt_used      = 1'b0;
    end
    // $0 is hardwired, so a write to it is dropped here rather than in writeback.
    if (ctrl.wsel == '0) begin
      ctrl.WEN = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// One-register decode pipeline stage with load-use interlock, flush and HALT lockout.
// Latency 1 cycle accept-to-out_valid; holds output while out_ready is low, flush overrides all.
module decode_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int REG_AW    = 5,
  parameter bit HAZARD_EN = 1'b1,
  parameter int LUI_SHIFT = 16
) (
  input logic           CLK,
  input logic           nRST,
  decode_stage_if.slave bus
);

  decode_ctrl_t      dec_ctrl;
  logic [WORD_W-1:0] dec_imm;
  logic              dec_rt_used;
  stage_state_t      state;
  logic              out_valid_q;
  decode_ctrl_t      ctrl_q;
  logic [WORD_W-1:0] imm_q;
  logic              hazard;
  logic              ready;
  logic              accept;
  logic              hit_rs;
  logic              hit_rt;

  instr_decoder #(
    .WORD_W   (WORD_W),
    .LUI_SHIFT(LUI_SHIFT)
  ) u_instr_decoder (
    .instr  (bus.instr_i),
    .ctrl   (dec_ctrl),
    .imm    (dec_imm),
    .rt_used(dec_rt_used)
  );

  assign hit_rs = (bus.ex_wsel_i == REG_AW'(dec_ctrl.rsel1));
  assign hit_rt = dec_rt_used && (bus.ex_wsel_i == REG_AW'(dec_ctrl.rsel2));
  assign hazard = HAZARD_EN && bus.in_valid && bus.ex_memread_i
                  && (bus.ex_wsel_i != '0) && (hit_rs || hit_rt);

  assign ready  = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush_i && (state == RUN);
  assign accept = bus.in_valid && ready;

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.ctrl_o    = ctrl_q;
  assign bus.imm_o     = imm_q;

  // Accepting HALT needs !flush_i, so a flushed HALT can never reach HALTED.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= RUN;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      imm_q       <= '0;
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec_ctrl;
      imm_q       <= dec_imm;
      if (dec_ctrl.halt) begin
        state <= HALTED;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
